codec_i2c_responder: RTL and testbench

CODEC_I2C_RESPONDER -- requirements
Module: codec_i2c_responder

---
 rtl/codec_i2c_responder.sv | 190 +++++++++++++++++++
 tb/tb_codec_i2c_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/codec_i2c_responder.sv
// I2C write-only responder for a codec control port.
// Accepts START, {DEVICE_ADDR, W}, {addr[6:0], data[8]}, data[7:0] and
// commits the 9-bit register write after the third ACK.
// Optional shadow register file: define CODEC_REGFILE_EN.
module codec_i2c_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h1A,
  parameter int         REG_COUNT   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       reg_valid,
  output logic       busy,
  input  logic [6:0] rd_addr,
  output logic [8:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, BYTE_HI, ACK_HI, BYTE_LO, ACK_LO, IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic        scl_p0, scl_p1, scl_p2;
  logic        sda_p0, sda_p1, sda_p2;
  logic        ack_on, ack_on_nxt;
  logic        busy_nxt;
  logic        commit, shift_en, cnt_clr, hi_load;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic [7:0]  hi_byte;
  logic [7:0]  rx_byte;
  logic        scl_rise, scl_fall, start_det, stop_det, byte_done;

  // Open-drain: only ever pull low
  assign I2C_SDAT = ack_on ? 1'b0 : 1'bz;

  // Stage p0/p1: two-flop synchronizers; stage p2: edge reference register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {I2C_SCLK, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {I2C_SDAT, sda_p0, sda_p1};
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign byte_done = scl_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {shift_q[6:0], sda_p1};

  // State register with the open-drain drive flag and busy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      ack_on <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ack_on <= ack_on_nxt;
      busy   <= busy_nxt;
    end
  end

  // Next-state logic; each ACK state drives SDA for one full SCL low/high/low span
  always_comb begin
    state_nxt  = state;
    ack_on_nxt = ack_on;
    busy_nxt   = busy;
    commit     = 1'b0;
    shift_en   = 1'b0;
    cnt_clr    = 1'b0;
    hi_load    = 1'b0;
    if (stop_det) begin
      state_nxt  = IDLE;
      ack_on_nxt = 1'b0;
      busy_nxt   = 1'b0;
    end else if (start_det) begin
      state_nxt  = ADDR;
      ack_on_nxt = 1'b0;
      busy_nxt   = 1'b0;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        ADDR: begin
          shift_en = scl_rise;
          if (byte_done) begin
            if (rx_byte == {DEVICE_ADDR, 1'b0}) begin
              state_nxt = ACK_ADDR;
              busy_nxt  = 1'b1;
            end else begin
              state_nxt = IGNORE;
              busy_nxt  = 1'b0;
            end
          end
        end
        BYTE_HI: begin
          shift_en = scl_rise;
          if (byte_done) begin
            state_nxt = ACK_HI;
            hi_load   = 1'b1;
          end
        end
        BYTE_LO: begin
          shift_en = scl_rise;
          if (byte_done) state_nxt = ACK_LO;
        end
        ACK_ADDR, ACK_HI, ACK_LO: begin
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_nxt = 1'b1;
            end else begin
              ack_on_nxt = 1'b0;
              case (state)
                ACK_ADDR: state_nxt = BYTE_HI;
                ACK_HI:   state_nxt = BYTE_LO;
                default: begin
                  state_nxt = IGNORE;
                  commit    = 1'b1;
                end
              endcase
            end
          end
        end
        IGNORE:  shift_en = scl_rise;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Bit counter and committed-write outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt   <= 3'd0;
      reg_addr  <= 7'd0;
      reg_data  <= 9'd0;
      reg_valid <= 1'b0;
    end else begin
      if (cnt_clr)       bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      reg_valid <= commit;
      if (commit) begin
        reg_addr <= hi_byte[7:1];
        reg_data <= {hi_byte[0], shift_q};
      end
    end
  end

  // Receive shift register and captured high byte
  always_ff @(posedge clk) begin
    if (shift_en) shift_q <= rx_byte;
    if (hi_load)  hi_byte <= rx_byte;
  end

`ifdef CODEC_REGFILE_EN
  localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic [8:0] shadow [REG_COUNT];
  logic [6:0] wr_addr;

  assign wr_addr = hi_byte[7:1];

  // Shadow registers: address 0x0F clears all, out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) shadow[i] <= 9'd0;
    end else if (commit) begin
      if (wr_addr == 7'h0F) begin
        for (int i = 0; i < REG_COUNT; i++) shadow[i] <= 9'd0;
      end else if (32'(wr_addr) < REG_COUNT) begin
        shadow[wr_addr[IDX_W-1:0]] <= {hi_byte[0], shift_q};
      end
    end
  end

  assign rd_data = (32'(rd_addr) < REG_COUNT) ? shadow[rd_addr[IDX_W-1:0]] : 9'd0;
`else
  logic rd_unused;

  assign rd_unused = ^rd_addr ^ (REG_COUNT > 0);
  assign rd_data   = 9'd0;
`endif

endmodule

// File: tb/tb_codec_i2c_responder.sv
// Bit-banged I2C master driving codec_i2c_responder, checked against a
// transaction-level model of the write protocol and shadow register file.
module tb_codec_i2c_responder;

  localparam int Q      = 50;   // quarter SCL period in ns (SCL = 20 clk)
  localparam int NREG   = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scl;
  logic       tb_low;
  wire        sda_bus;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       reg_valid;
  logic       busy;
  logic [6:0] rd_addr;
  logic [8:0] rd_data;

  assign sda_bus = tb_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  codec_i2c_responder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .I2C_SCLK (scl),
    .I2C_SDAT (sda_bus),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .reg_valid(reg_valid),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [6:0] exp_addr = 7'd0;
  logic [8:0] exp_data = 9'd0;
  int         exp_commits = 0;
  logic [8:0] shadow_m [NREG];

  // Observed activity
  int   pulses = 0;
  int   pulse_cycles = 0;
  int   dut_pulls = 0;
  logic rv_prev = 1'b0;

  always @(negedge clk) begin
    if (reg_valid) pulse_cycles++;
    if (reg_valid && !rv_prev) pulses++;
    rv_prev = reg_valid;
    if (sda_bus === 1'b0 && !tb_low) dut_pulls++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_rd(input logic [6:0] a);
`ifdef CODEC_REGFILE_EN
    return (int'(a) < NREG) ? shadow_m[a[3:0]] : 9'd0;
`else
    return 9'd0;
`endif
  endfunction

  task automatic model_reset();
    exp_addr = 7'd0;
    exp_data = 9'd0;
    for (int i = 0; i < NREG; i++) shadow_m[i] = 9'd0;
  endtask

  task automatic model_commit(input logic [7:0] hi, input logic [7:0] lo);
    exp_addr = hi[7:1];
    exp_data = {hi[0], lo};
    exp_commits++;
    if (exp_addr == 7'h0F) begin
      for (int i = 0; i < NREG; i++) shadow_m[i] = 9'd0;
    end else if (int'(exp_addr) < NREG) begin
      shadow_m[exp_addr[3:0]] = exp_data;
    end
  endtask

  task automatic i2c_start();
    tb_low = 1'b0; #Q;
    scl = 1'b1;    #Q;
    tb_low = 1'b1; #Q;
    scl = 1'b0;    #Q;
  endtask

  task automatic i2c_stop();
    tb_low = 1'b1; #Q;
    scl = 1'b1;    #Q;
    tb_low = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      tb_low = ~b[i]; #Q;
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    tb_low = 1'b0; #Q;
    scl = 1'b1;    #Q;
    ack = sda_bus; #Q;
    scl = 1'b0;    #Q;
  endtask

  // One transaction: START, n bytes, optional STOP (else next START is repeated)
  task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int n, input bit do_stop,
                         input logic [6:0] ra);
    logic [7:0] bytes [4];
    logic       ack;
    logic       addr_ok;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    addr_ok = (b0 == 8'h34);
    i2c_start();
    for (int k = 0; k < n; k++) begin
      send_byte(bytes[k], ack);
      check_eq("ack", 32'(ack), (addr_ok && k < 3) ? 32'd0 : 32'd1);
      if (k == 0) check_eq("busy_addr", 32'(busy), 32'(addr_ok));
    end
    if (addr_ok && n >= 3) model_commit(bytes[1], bytes[2]);
    if (do_stop) begin
      i2c_stop();
      #(4*Q);
      check_eq("busy_stop", 32'(busy), 32'd0);
    end
    check_eq("pulses", 32'(pulses), 32'(exp_commits));
    check_eq("pulse_width", 32'(pulse_cycles), 32'(exp_commits));
    check_eq("reg_addr", 32'(reg_addr), 32'(exp_addr));
    check_eq("reg_data", 32'(reg_data), 32'(exp_data));
    rd_addr = ra; #1;
    check_eq("rd_data", 32'(rd_data), 32'(model_rd(ra)));
  endtask

  initial begin
    int pulls0;
    logic [7:0] b0, b1;
    reset_n = 1'b0; scl = 1'b1; tb_low = 1'b0; rd_addr = 7'd0;
    model_reset();
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("rst_reg_data", 32'(reg_data), 32'd0);
    check_eq("rst_reg_valid", 32'(reg_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sda", 32'(sda_bus), 32'd1);
    reset_n = 1'b1;
    #(4*Q);

    // Basic write: reg 4 <= 0x012
    run_txn(8'h34, 8'h08, 8'h12, 8'h00, 3, 1'b1, 7'd4);
    check_eq("w1_addr", 32'(reg_addr), 32'h04);
    check_eq("w1_data", 32'(reg_data), 32'h012);

    // Wrong address: never driven low, busy stays low
    pulls0 = dut_pulls;
    run_txn(8'h36, 8'h00, 8'h00, 8'h00, 1, 1'b1, 7'd4);
    check_eq("wrong_addr_pulls", 32'(dut_pulls - pulls0), 32'd0);

    // Read request: NACK, no commit
    run_txn(8'h35, 8'h08, 8'h55, 8'h00, 3, 1'b1, 7'd4);

    // Partial write discarded, then full write commits
    run_txn(8'h34, 8'h0D, 8'h00, 8'h00, 2, 1'b1, 7'd6);
    run_txn(8'h34, 8'h0D, 8'hFF, 8'h00, 3, 1'b1, 7'd6);
    check_eq("w2_addr", 32'(reg_addr), 32'h06);
    check_eq("w2_data", 32'(reg_data), 32'h1FF);

    // Clear via register 0x0F
    run_txn(8'h34, 8'h08, 8'h12, 8'h00, 3, 1'b1, 7'd4);
    run_txn(8'h34, 8'h1E, 8'h00, 8'h00, 3, 1'b1, 7'd4);

    // Reset in the middle of the high byte
    i2c_start();
    begin
      logic ack;
      send_byte(8'h34, ack);
      check_eq("mid_ack", 32'(ack), 32'd0);
    end
    send_bits(8'hA5, 3);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_eq("midrst_reg_addr", 32'(reg_addr), 32'd0);
    check_eq("midrst_reg_data", 32'(reg_data), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_sda", 32'(sda_bus), 32'd1);
    reset_n = 1'b1;
    scl = 1'b1; #Q;
    tb_low = 1'b0; #(2*Q);
    run_txn(8'h34, 8'h0A, 8'h3C, 8'h00, 3, 1'b1, 7'd5);

    // Randomized traffic, including repeated STARTs and early STOPs
    for (int t = 0; t < 30; t++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       b0 = 8'h34;
      else if (sel == 7) b0 = 8'h35;
      else               b0 = 8'($urandom);
      b1 = ($urandom_range(0, 7) == 0) ? 8'h1E
                                       : {7'($urandom_range(0, 20)), 1'($urandom)};
      run_txn(b0, b1, 8'($urandom), 8'($urandom), int'($urandom_range(1, 4)),
              ($urandom_range(0, 4) != 0) || (t == 29), 7'($urandom_range(0, 20)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
